// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronizer, start-bit validation at mid-bit, byte output
// with one-cycle valid strobe and framing-error pulse; a held-low line parks in a break state.
`timescale 1ns/1ps
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned Half = CLKS_PER_BIT / 2;
  localparam logic [CntW-1:0] CntHalfLast = CntW'(Half - 1);
  localparam logic [CntW-1:0] CntBitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] CntOne      = CntW'(1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

  logic            r_sync1;
  logic            r_rx_s;
  state_e          r_state;
  state_e          w_state_nxt;
  logic [CntW-1:0] r_cnt;
  logic [CntW-1:0] w_cnt_nxt;
  logic [2:0]      r_bit_idx;
  logic [2:0]      w_bit_idx_nxt;
  logic [7:0]      r_shift;
  logic [7:0]      w_shift_nxt;
  logic [7:0]      r_data;
  logic [7:0]      w_data_nxt;
  logic            r_valid;
  logic            w_valid_nxt;
  logic            r_err;
  logic            w_err_nxt;

  // Synchronizer idles high so reset release never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_rx_s  <= 1'b1;
    end else begin
      r_sync1 <= rx_in;
      r_rx_s  <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
      r_data    <= w_data_nxt;
      r_valid   <= w_valid_nxt;
      r_err     <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_data_nxt    = r_data;
    w_valid_nxt   = 1'b0;
    w_err_nxt     = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_cnt_nxt = '0;
        if (!r_rx_s) w_state_nxt = StStart;
      end
      StStart: begin
        if (r_cnt == CntHalfLast) begin
          w_cnt_nxt = '0;
          if (!r_rx_s) begin
            w_state_nxt   = StData;
            w_bit_idx_nxt = '0;
          end else begin
            w_state_nxt = StIdle;
          end
        end else begin
          w_cnt_nxt = r_cnt + CntOne;
        end
      end
      StData: begin
        if (r_cnt == CntBitLast) begin
          w_cnt_nxt              = '0;
          w_shift_nxt[r_bit_idx] = r_rx_s;
          w_bit_idx_nxt          = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) w_state_nxt = StStop;
        end else begin
          w_cnt_nxt = r_cnt + CntOne;
        end
      end
      StStop: begin
        if (r_cnt == CntBitLast) begin
          w_cnt_nxt = '0;
          if (r_rx_s) begin
            w_data_nxt  = r_shift;
            w_valid_nxt = 1'b1;
            w_state_nxt = StIdle;
          end else begin
            w_err_nxt   = 1'b1;
            w_state_nxt = StBreak;
          end
        end else begin
          w_cnt_nxt = r_cnt + CntOne;
        end
      end
      StBreak: begin
        if (r_rx_s) w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  assign rx_data   = r_data;
  assign rx_valid  = r_valid;
  assign frame_err = r_err;
  assign rx_busy   = (r_state != StIdle);

endmodule

// File: tb/tb_uart_rx.sv
// Randomized bench for uart_rx: three instances (16, 4 and 5 clocks per bit) checked against
// an event-queue model of when each frame's valid or framing-error pulse must appear.
`timescale 1ns/1ps
module tb_uart_rx;

  typedef struct {
    logic [7:0] data;
    int         cyc;
    logic       err;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx0, rx1, rx2;
  logic [7:0] d0, d1, d2;
  logic       v0, v1, v2;
  logic       e0, e1, e2;
  logic       b0, b1, b2;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_errors = 0;
  ev_t        q0[$];
  ev_t        q1[$];
  ev_t        q2[$];
  logic [7:0] last_good[3];
  int         last_pulse[3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_rx #(.CLKS_PER_BIT(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .rx_in(rx0), .rx_data(d0), .rx_valid(v0), .frame_err(e0),
    .rx_busy(b0)
  );
  uart_rx #(.CLKS_PER_BIT(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .rx_in(rx1), .rx_data(d1), .rx_valid(v1), .frame_err(e1),
    .rx_busy(b1)
  );
  uart_rx #(.CLKS_PER_BIT(5)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .rx_in(rx2), .rx_data(d2), .rx_valid(v2), .frame_err(e2),
    .rx_busy(b2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int cpb_of(input int u);
    return (u == 0) ? 16 : (u == 1) ? 4 : 5;
  endfunction

  task automatic set_line(input int u, input logic val);
    case (u)
      0: rx0 = val;
      1: rx1 = val;
      default: rx2 = val;
    endcase
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_ev(input int u, input ev_t ev);
    case (u)
      0: q0.push_back(ev);
      1: q1.push_back(ev);
      default: q2.push_back(ev);
    endcase
  endtask

  // Each pulse must match the oldest outstanding model event in kind, cycle and data.
  task automatic observe(input int u, input logic v, input logic e, input logic [7:0] d);
    ev_t ex;
    int  have;
    have = 0;
    case (u)
      0: if (q0.size() != 0) begin ex = q0.pop_front(); have = 1; end
      1: if (q1.size() != 0) begin ex = q1.pop_front(); have = 1; end
      default: if (q2.size() != 0) begin ex = q2.pop_front(); have = 1; end
    endcase
    check("event_expected", have, 1);
    if (have != 0) begin
      check("event_kind", {30'd0, v, e}, ex.err ? 32'd1 : 32'd2);
      check("event_cycle", cyc, ex.cyc);
      check("rx_data", {24'd0, d}, {24'd0, ex.data});
    end
    check("pulse_spacing", (cyc == last_pulse[u] + 1) ? 1 : 0, 0);
    last_pulse[u] = cyc;
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (v0 || e0) observe(0, v0, e0, d0);
      if (v1 || e1) observe(1, v1, e1, d1);
      if (v2 || e2) observe(2, v2, e2, d2);
    end
  end

  // Called at posedge+1; abort_at >= 0 stops mid data bit abort_at with no expected event.
  task automatic send_frame(input int u, input logic [7:0] b, input logic stop_bit,
                            input int abort_at);
    int  cpb;
    int  edge0;
    ev_t ev;
    cpb   = cpb_of(u);
    edge0 = cyc + 1;
    set_line(u, 1'b0);
    wait_cycles(cpb);
    for (int i = 0; i < 8; i++) begin
      if (i == abort_at) begin
        set_line(u, b[i]);
        wait_cycles(cpb / 2);
        return;
      end
      set_line(u, b[i]);
      wait_cycles(cpb);
    end
    set_line(u, stop_bit);
    ev.cyc = edge0 + 2 + cpb / 2 + 9 * cpb;
    ev.err = !stop_bit;
    if (stop_bit) last_good[u] = b;
    ev.data = last_good[u];
    push_ev(u, ev);
    wait_cycles(cpb);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    rst_n = 1'b0;
    rx0 = 1'b1; rx1 = 1'b1; rx2 = 1'b1;
    for (int u = 0; u < 3; u++) begin
      last_good[u]  = 8'h00;
      last_pulse[u] = -10;
    end
    wait_cycles(3);
    check("reset_outputs", {d0, v0, e0, b0}, 0);
    rst_n = 1'b1;
    wait_cycles(3);
    check("idle_busy", b0, 0);

    // Single frame with exact timing.
    send_frame(0, 8'hA5, 1'b1, -1);
    wait_cycles(20);
    check("a5_held", d0, 8'hA5);

    // Back-to-back frames without idle gap.
    send_frame(0, 8'h00, 1'b1, -1);
    send_frame(0, 8'hFF, 1'b1, -1);
    wait_cycles(20);

    // Short glitch must be rejected.
    seen = 0;
    set_line(0, 1'b0);
    wait_cycles(4);
    set_line(0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (b0) seen = 1;
    end
    check("glitch_busy_seen", seen, 1);
    check("glitch_busy_clear", b0, 0);
    wait_cycles(5);
    send_frame(0, 8'h3C, 1'b1, -1);
    wait_cycles(20);

    // Framing error followed by a long break.
    send_frame(0, 8'h5A, 1'b0, -1);
    wait_cycles(40);
    check("break_busy", b0, 1);
    check("break_data_kept", d0, 8'h3C);
    set_line(0, 1'b1);
    wait_cycles(4);
    check("break_exit", b0, 0);
    send_frame(0, 8'h81, 1'b1, -1);
    wait_cycles(20);

    // Reset in the middle of data bit 4.
    send_frame(0, 8'hC3, 1'b1, 4);
    #2 rst_n = 1'b0;
    #1 check("midreset_outputs", {d0, v0, e0, b0}, 0);
    wait_cycles(3);
    check("midreset_hold", {d0, v0, e0, b0}, 0);
    set_line(0, 1'b1);
    rst_n = 1'b1;
    for (int u = 0; u < 3; u++) last_good[u] = 8'h00;
    wait_cycles(5);
    check("post_reset_idle", {d0, b0}, 0);
    send_frame(0, 8'h7E, 1'b1, -1);
    wait_cycles(20);

    // Random bytes on every bit rate, random idle gaps including none.
    for (int u = 0; u < 3; u++) begin
      for (int k = 0; k < 10; k++) begin
        send_frame(u, 8'($urandom_range(0, 255)), 1'b1, -1);
        if ($urandom_range(0, 1) != 0) wait_cycles($urandom_range(1, 6));
      end
      wait_cycles(30);
    end

    wait_cycles(50);
    check("q_empty_16", q0.size(), 0);
    check("q_empty_4", q1.size(), 0);
    check("q_empty_5", q2.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
